// File: rtl/alu_exec_unit.sv
// RV32I/M execute stage: single-cycle ALU ops in 1 cycle, iterative MUL/DIV in XLEN+2 cycles.
// in_ready drops while an M-op iterates or while an unconsumed result is held with out_ready low.
module alu_exec_unit #(
   parameter int XLEN     = 32,
   parameter bit ENABLE_M = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        aluop,
   input  logic [6:0]        func7,
   input  logic [2:0]        func3,
   input  logic [XLEN-1:0]   op_a,
   input  logic [XLEN-1:0]   op_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   result,
   output logic              illegal
);
   localparam int SHW = $clog2(XLEN);
   localparam logic [SHW-1:0] CNT_LAST = SHW'(XLEN - 1);

   typedef enum logic [4:0] {
      OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
   } op_t;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIN} state_t;

   state_t state, state_n;
   op_t    dec_op, m_op;
   logic   dec_ill, dec_m, accept;
   logic [XLEN-1:0]   alu_res, fin_res, a_q, b_q, md, ua, ub;
   logic [2*XLEN-1:0] acc, acc_n, prod;
   logic [SHW-1:0]    cnt;
   logic a_sgn, b_sgn, as_q, bs_q;

   function automatic op_t base_op(input logic [2:0] f3);
      case (f3)
         3'b000:  return OP_ADD;
         3'b001:  return OP_SLL;
         3'b010:  return OP_SLT;
         3'b011:  return OP_SLTU;
         3'b100:  return OP_XOR;
         3'b101:  return OP_SRL;
         3'b110:  return OP_OR;
         default: return OP_AND;
      endcase
   endfunction

   function automatic op_t mext_op(input logic [2:0] f3);
      case (f3)
         3'b000:  return OP_MUL;
         3'b001:  return OP_MULH;
         3'b010:  return OP_MULHSU;
         3'b011:  return OP_MULHU;
         3'b100:  return OP_DIV;
         3'b101:  return OP_DIVU;
         3'b110:  return OP_REM;
         default: return OP_REMU;
      endcase
   endfunction

   always_comb begin
      dec_op  = OP_ADD;
      dec_ill = 1'b0;
      case (aluop)
         2'b00: dec_op = OP_ADD;
         2'b01: dec_op = OP_SUB;
         2'b10: begin
            if (func7 == 7'b0000000) begin
               dec_op = base_op(func3);
            end else if (func7 == 7'b0100000) begin
               if (func3 == 3'b000)      dec_op = OP_SUB;
               else if (func3 == 3'b101) dec_op = OP_SRA;
               else                      dec_ill = 1'b1;
            end else if (func7 == 7'b0000001 && ENABLE_M) begin
               dec_op = mext_op(func3);
            end else begin
               dec_ill = 1'b1;
            end
         end
         default: begin
            // I-type: func7 only qualifies the shift encodings
            if (func3 == 3'b001) begin
               if (func7 == 7'b0000000) dec_op = OP_SLL;
               else                     dec_ill = 1'b1;
            end else if (func3 == 3'b101) begin
               if (func7 == 7'b0000000)      dec_op = OP_SRL;
               else if (func7 == 7'b0100000) dec_op = OP_SRA;
               else                          dec_ill = 1'b1;
            end else begin
               dec_op = base_op(func3);
            end
         end
      endcase
   end

   assign dec_m    = !dec_ill && (dec_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                                                 OP_DIV, OP_DIVU, OP_REM, OP_REMU});
   assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      alu_res = '0;
      case (dec_op)
         OP_ADD:  alu_res = op_a + op_b;
         OP_SUB:  alu_res = op_a - op_b;
         OP_SLL:  alu_res = op_a << op_b[SHW-1:0];
         OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
         OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
         OP_XOR:  alu_res = op_a ^ op_b;
         OP_SRL:  alu_res = op_a >> op_b[SHW-1:0];
         OP_SRA:  alu_res = $unsigned($signed(op_a) >>> op_b[SHW-1:0]);
         OP_OR:   alu_res = op_a | op_b;
         OP_AND:  alu_res = op_a & op_b;
         default: alu_res = '0;
      endcase
   end

   // The iterative core works on magnitudes; signs are reapplied in FIN.
   assign a_sgn = op_a[XLEN-1] && (dec_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
   assign b_sgn = op_b[XLEN-1] && (dec_op inside {OP_MULH, OP_DIV, OP_REM});
   assign ua    = a_sgn ? -op_a : op_a;
   assign ub    = b_sgn ? -op_b : op_b;

   // acc holds {partial, multiplier} for MUL and {remainder, quotient} for DIV.
   logic [XLEN:0]   mul_sum, div_sh;
   logic [XLEN-1:0] div_rem;
   logic            div_ge, is_div;

   always_comb begin
      is_div  = m_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
      mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, md} : {(XLEN+1){1'b0}});
      div_sh  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      div_ge  = div_sh >= {1'b0, md};
      div_rem = div_ge ? (div_sh[XLEN-1:0] - md) : div_sh[XLEN-1:0];
      acc_n   = is_div ? {div_rem, acc[XLEN-2:0], div_ge} : {mul_sum, acc[XLEN-1:1]};
   end

   always_comb begin
      prod    = (as_q ^ bs_q) ? -acc : acc;
      fin_res = '0;
      case (m_op)
         OP_MUL:                       fin_res = prod[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fin_res = prod[2*XLEN-1:XLEN];
         OP_DIV:  fin_res = (b_q == '0) ? '1 :
                            ((as_q ^ bs_q) ? -acc[XLEN-1:0] : acc[XLEN-1:0]);
         OP_DIVU: fin_res = acc[XLEN-1:0];
         OP_REM:  fin_res = (b_q == '0) ? a_q :
                            (as_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN]);
         OP_REMU: fin_res = acc[2*XLEN-1:XLEN];
         default: fin_res = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:  if (accept && dec_m) state_n = S_BUSY;
         S_BUSY:  if (cnt == CNT_LAST) state_n = S_FIN;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt  <= '0;
         acc  <= '0;
         md   <= '0;
         m_op <= OP_ADD;
         a_q  <= '0;
         b_q  <= '0;
         as_q <= 1'b0;
         bs_q <= 1'b0;
      end else if (state == S_IDLE && accept && dec_m) begin
         cnt  <= '0;
         m_op <= dec_op;
         a_q  <= op_a;
         b_q  <= op_b;
         as_q <= a_sgn;
         bs_q <= b_sgn;
         if (dec_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU}) begin
            acc <= {{XLEN{1'b0}}, ua};
            md  <= ub;
         end else begin
            acc <= {{XLEN{1'b0}}, ub};
            md  <= ua;
         end
      end else if (state == S_BUSY) begin
         acc <= acc_n;
         cnt <= cnt + SHW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         result    <= '0;
         illegal   <= 1'b0;
      end else if (state == S_FIN) begin
         out_valid <= 1'b1;
         result    <= fin_res;
         illegal   <= 1'b0;
      end else if (accept && !dec_m) begin
         out_valid <= 1'b1;
         result    <= dec_ill ? '0 : alu_res;
         illegal   <= dec_ill;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end
endmodule
